uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte producers. Each producer offers a byte over a valid/ready handshake. The arbiter accepts one byte at a time, launches the transmitter with a single-cycle start pulse, and holds the data stable until the transmitter reports completion. It sits between the application-side byte sources and the single `uart_tx` instance driving the TX pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Build option: UART_ARB_TAG_EN adds the tag-frame states.
package uart_pkg;

`ifdef UART_ARB_TAG_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_TAG_START = 3'd3,
        ST_TAG_WAIT  = 3'd4
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;
`endif

    localparam logic [7:0] TAG_BASE = 8'hA0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes plus the transmitter control pair, bundled for the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_busy;
    logic                         tx_done;

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_start, tx_data
    );

    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from last+1.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [idx_width(NUM_REQ)-1:0]   last,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [idx_width(NUM_REQ)-1:0]   idx,
    output logic                            any
);
    localparam int IW = idx_width(NUM_REQ);

    logic [IW-1:0] cand_idx;
    logic          hit;

    // Walk the NUM_REQ candidates in priority order; only the first hit sticks.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand_idx = '0;
        hit      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IW'((int'(last) + k) % NUM_REQ);
            hit      = ~any & req[cand_idx];
            gnt      = gnt | (NUM_REQ'(hit) << cand_idx);
            idx      = hit ? cand_idx : idx;
            any      = any | hit;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Build option: UART_ARB_TAG_EN sends a TAG_BASE|grant_id frame ahead of each payload byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    uart_tx_arbiter_if.slave               bus,
    output logic [idx_width(NUM_REQ)-1:0]  grant_id,
    output logic                           busy
);
    localparam int IW = idx_width(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        grant_id_q, grant_id_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
`ifdef UART_ARB_TAG_EN
    logic [DATA_BITS-1:0] hold_q, hold_d;
`endif

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [DATA_BITS-1:0] pick_data;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (bus.req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign pick_data = bus.req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];

    // Ready is offered only while idle and never while reset is asserted.
    always_comb begin
        if ((state_q == ST_IDLE) && !rst) begin
            bus.req_ready = pick_gnt;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Next-state logic; entering a start state pre-arms the pulse when the line is free.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        tx_start_d = 1'b0;
`ifdef UART_ARB_TAG_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    tx_start_d = ~bus.tx_busy;
`ifdef UART_ARB_TAG_EN
                    hold_d     = pick_data;
                    tx_data_d  = DATA_BITS'(TAG_BASE) | DATA_BITS'(pick_idx);
                    state_d    = ST_TAG_START;
`else
                    tx_data_d  = pick_data;
                    state_d    = ST_START;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_start_q) begin
                    state_d = ST_WAIT_DONE;
                end else if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    last_d  = grant_id_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG_START: begin
                if (tx_start_q) begin
                    state_d = ST_TAG_WAIT;
                end else if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                end else begin
                    state_d = ST_TAG_START;
                end
            end
            ST_TAG_WAIT: begin
                if (bus.tx_done) begin
                    tx_data_d  = hold_q;
                    tx_start_d = ~bus.tx_busy;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_TAG_WAIT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; last starts at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            last_q     <= IW'(NUM_REQ - 1);
            grant_id_q <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_ARB_TAG_EN
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
`ifdef UART_ARB_TAG_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign grant_id     = grant_id_q;
    assign busy         = busy_q;

endmodule
